// File: rtl/dpll_pkg.sv
// Shared types, defaults and saturating arithmetic for the DPLL loop filter/NCO.
package dpll_pkg;

   typedef enum logic [1:0] {ERR_NONE, ERR_UP, ERR_DN} err_t;

   localparam logic [15:0] FTW_NOM_DEF = 16'h1000;
   localparam logic [15:0] KP_DEF      = 16'h0100;
   localparam logic [11:0] KI_DEF      = 12'h010;

   // Symmetric saturation to +/-lim; a saturated integrator holds instead of wrapping.
   function automatic int sat_add(input int a, input int b, input int lim);
      int s;
      s = a + b;
      if (s > lim)
         s = lim;
      else if (s < -lim)
         s = -lim;
      return s;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/fb_divider.sv
// Divides the NCO output by DIV_N on its rising edges, producing a 50% duty feedback clock.
module fb_divider #(
   parameter int DIV_N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_out,
   output logic clk_fb
);

   localparam int CW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_N - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV_N / 2);

   logic          msb_q;
   logic          rise;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;

   assign rise   = clk_out & ~msb_q;
   assign cnt_nx = (cnt == LAST) ? '0 : cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         msb_q  <= 1'b0;
         cnt    <= '0;
         clk_fb <= 1'b0;
      end else begin
         msb_q <= clk_out;
         if (rise) begin
            cnt    <= cnt_nx;
            clk_fb <= (cnt_nx < HALF);
         end
      end
   end

endmodule

// File: rtl/dpll_nco_feedback.sv
// PI loop filter, phase-accumulator NCO and lock detector closing the ADPLL around the PFD.
module dpll_nco_feedback
   import dpll_pkg::*;
#(
   parameter int                ACC_W    = 16,
   parameter int                CTRL_W   = 12,
   parameter logic [ACC_W-1:0]  FTW_NOM  = FTW_NOM_DEF,
   parameter logic [ACC_W-1:0]  KP       = KP_DEF,
   parameter logic [CTRL_W-1:0] KI       = KI_DEF,
   parameter int                DIV_N    = 4,
   parameter int                LOCK_TOL = 2,
   parameter int                LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             down,
   output logic             clk_out,
   output logic             clk_fb,
   output logic [ACC_W-1:0] ftw,
   output logic             locked
);

   localparam int EW = $clog2(LOCK_TOL + 2);
   localparam int QW = $clog2(LOCK_CNT + 1);
   localparam logic [EW-1:0] ERR_TOL = EW'(LOCK_TOL);
   localparam logic [EW-1:0] ERR_SAT = EW'(LOCK_TOL + 1);
   localparam logic [QW-1:0] QMAX    = QW'(LOCK_CNT);

   err_t                     err;
   int                       err_i;
   int                       integ_nx;
   int                       ftw_nx;
   logic signed [CTRL_W-1:0] integ;
   logic [ACC_W-1:0]         phase;
   logic                     fb_q;
   logic                     fb_rise;
   logic [EW-1:0]            err_cnt;
   logic [QW-1:0]            quiet;
   logic [QW-1:0]            quiet_nx;

   always_comb begin
      err = ERR_NONE;
      if (en && up && !down)
         err = ERR_UP;
      else if (en && down && !up)
         err = ERR_DN;
   end

   // Filter math in 32-bit signed ints: wide enough that nothing wraps before the clamp.
   always_comb begin
      err_i    = (err == ERR_UP) ? 1 : ((err == ERR_DN) ? -1 : 0);
      integ_nx = sat_add(int'(integ), err_i * int'(KI), 2**(CTRL_W-1) - 1);
      ftw_nx   = clamp(int'(FTW_NOM) + integ_nx + err_i * int'(KP), 1, 2**(ACC_W-1));
   end

   assign clk_out = phase[ACC_W-1];
   assign fb_rise = clk_fb & ~fb_q;

   always_comb begin
      quiet_nx = quiet;
      if (fb_rise)
         quiet_nx = (err_cnt <= ERR_TOL) ? ((quiet == QMAX) ? quiet : quiet + QW'(1)) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         integ   <= '0;
         ftw     <= FTW_NOM;
         phase   <= '0;
         fb_q    <= 1'b0;
         err_cnt <= '0;
         quiet   <= '0;
         locked  <= 1'b0;
      end else begin
         integ  <= CTRL_W'(integ_nx);
         ftw    <= ACC_W'(ftw_nx);
         phase  <= phase + ftw;
         fb_q   <= clk_fb;
         quiet  <= quiet_nx;
         locked <= (quiet_nx == QMAX);
         if (fb_rise)
            err_cnt <= '0;
         else if (err != ERR_NONE && err_cnt != ERR_SAT)
            err_cnt <= err_cnt + EW'(1);
      end
   end

   fb_divider #(.DIV_N(DIV_N)) u_fb_divider (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_out (clk_out),
      .clk_fb  (clk_fb)
   );

endmodule

// File: tb/tb_dpll_nco_feedback.sv
// Cycle scoreboard against a behavioural loop model, plus directed checks of the key loop values.
module tb_dpll_nco_feedback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b0;
   logic        down = 1'b0;
   logic        clk_out;
   logic        clk_fb;
   logic        locked;
   logic [15:0] ftw;

   dpll_nco_feedback dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .up      (up),
      .down    (down),
      .clk_out (clk_out),
      .clk_fb  (clk_fb),
      .ftw     (ftw),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] ftw;
      logic        co;
      logic        fb;
      logic        lk;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   int m_integ, m_ftw, m_phase, m_msbq, m_cnt, m_fb, m_fbq, m_errc, m_quiet, m_lk;
   bit m_fbr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // One clock edge of the reference loop, all updates from pre-edge state.
   task automatic model_edge(input bit r, input bit e, input bit u, input bit d);
      int  er, ni, nf, co;
      bit  rise;
      m_fbr = 1'b0;
      if (!r) begin
         m_integ = 0; m_ftw = 4096; m_phase = 0; m_msbq = 0; m_cnt = 0;
         m_fb = 0; m_fbq = 0; m_errc = 0; m_quiet = 0; m_lk = 0;
      end else begin
         er = (e && u && !d) ? 1 : ((e && d && !u) ? -1 : 0);
         ni = m_integ + 16 * er;
         if (ni > 2047) ni = 2047;
         if (ni < -2047) ni = -2047;
         nf = 4096 + ni + 256 * er;
         if (nf < 1) nf = 1;
         if (nf > 32768) nf = 32768;
         co    = (m_phase >> 15) & 1;
         rise  = (co == 1) && (m_msbq == 0);
         m_fbr = (m_fb == 1) && (m_fbq == 0);
         m_fbq  = m_fb;
         m_msbq = co;
         if (rise) begin
            m_cnt = (m_cnt + 1) % 4;
            m_fb  = (m_cnt < 2) ? 1 : 0;
         end
         if (m_fbr) begin
            m_quiet = (m_errc <= 2) ? ((m_quiet < 4) ? m_quiet + 1 : 4) : 0;
            m_errc  = 0;
         end else if (er != 0 && m_errc < 3) begin
            m_errc++;
         end
         m_lk    = (m_quiet == 4) ? 1 : 0;
         m_phase = (m_phase + m_ftw) & 32'hFFFF;
         m_integ = ni;
         m_ftw   = nf;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit u, input bit d);
      exp_t x, g;
      rst_n = r; en = e; up = u; down = d;
      model_edge(r, e, u, d);
      x.ftw = 16'(m_ftw);
      x.co  = m_phase[15];
      x.fb  = m_fb[0];
      x.lk  = m_lk[0];
      sb.push_back(x);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("sb_ftw", ftw, g.ftw);
      chk("sb_clk_out", clk_out, g.co);
      chk("sb_clk_fb", clk_fb, g.fb);
      chk("sb_locked", locked, g.lk);
      cyc++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  co_r[$];
      int  fb_r[$];
      bit  pco, pfb, u, pulsed, seen;
      int  rises;

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_ftw", ftw, 16'h1000);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_clk_fb", clk_fb, 0);
      chk("rst_locked", locked, 0);

      // Freerun holdover: nominal tuning word, measured output periods.
      pco = clk_out; pfb = clk_fb;
      for (int i = 0; i < 160; i++) begin
         step(1, 0, 1, 0);
         if (clk_out && !pco) co_r.push_back(cyc);
         if (clk_fb && !pfb) fb_r.push_back(cyc);
         pco = clk_out; pfb = clk_fb;
      end
      chk("free_ftw", ftw, 16'h1000);
      chk("free_locked", locked, 0);
      if (co_r.size() >= 3) chk("free_co_period", co_r[2] - co_r[1], 16);
      else chk("free_co_edges", co_r.size(), 3);
      if (fb_r.size() >= 3) chk("free_fb_period", fb_r[2] - fb_r[1], 64);
      else chk("free_fb_edges", fb_r.size(), 3);

      // Single up / single down error cycle.
      step(0, 0, 0, 0);
      step(1, 1, 1, 0);
      chk("up1_ftw", ftw, 16'h1110);
      step(1, 1, 0, 0);
      chk("up1_ftw_after", ftw, 16'h1010);
      step(0, 0, 0, 0);
      step(1, 1, 0, 1);
      chk("dn1_ftw", ftw, 16'h0EF0);
      step(1, 1, 0, 0);
      chk("dn1_ftw_after", ftw, 16'h0FF0);

      // Conflicting up and down cancel.
      step(0, 0, 0, 0);
      repeat (10) step(1, 1, 1, 1);
      chk("both_ftw", ftw, 16'h1000);
      chk("both_integ", dut.integ, 0);

      // Lock acquisition with one error cycle per feedback period.
      step(0, 0, 0, 0);
      rises = 0; pulsed = 0;
      for (int i = 0; i < 1000 && rises < 4; i++) begin
         u = !pulsed && m_fb == 1 && m_fbq == 1;
         if (u) pulsed = 1;
         step(1, 1, u, 0);
         if (m_fbr) begin
            rises++;
            pulsed = 0;
            if (rises == 3) chk("lock_3rd", locked, 0);
         end
      end
      chk("lock_rises", rises, 4);
      chk("lock_4th", locked, 1);

      // Three-cycle burst breaks lock at the next feedback edge.
      for (int i = 0; i < 200 && !(m_fb == 1 && m_fbq == 1); i++) step(1, 1, 0, 0);
      repeat (3) step(1, 1, 1, 0);
      chk("burst_pre", locked, 1);
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         step(1, 1, 0, 0);
         seen = m_fbr;
      end
      chk("burst_seen", seen, 1);
      chk("burst_unlock", locked, 0);

      // Integrator saturation, then reset while locked at max tuning word.
      step(0, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
         step(1, 1, 1, 0);
         if (i == 126) chk("sat_integ_127", dut.integ, 12'h7F0);
         if (i == 127) chk("sat_integ_128", dut.integ, 12'h7FF);
      end
      step(1, 1, 0, 0);
      chk("sat_ftw", ftw, 16'h17FF);
      for (int i = 0; i < 600 && m_lk == 0; i++) step(1, 1, 0, 0);
      chk("hold_ftw", ftw, 16'h17FF);
      chk("hold_locked", locked, 1);
      step(0, 1, 0, 0);
      chk("mid_rst_ftw", ftw, 16'h1000);
      chk("mid_rst_clk_out", clk_out, 0);
      chk("mid_rst_clk_fb", clk_fb, 0);
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_integ", dut.integ, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dpll_nco_feedback.md
# dpll_nco_feedback

Digital loop filter, numerically controlled oscillator and feedback divider that close the all-digital PLL around the phase frequency detector. Consumes the detector's `up`/`down` error pulses, integrates them in a proportional-integral filter, and steers a phase-accumulator NCO. Produces `clk_out` and the divided feedback `clk_fb` that returns to the detector, plus a lock indicator.

## Interface
- `ACC_W`, 16: phase accumulator and tuning-word width.
- `CTRL_W`, 12: signed integrator width.
- `FTW_NOM`, 16'h1000: nominal tuning word, loaded at reset.
- `KP`, 16'h0100: proportional step per error cycle.
- `KI`, 12'h010: integral step per error cycle.
- `DIV_N`, 4: feedback divide ratio; even, ≥2.
- `LOCK_TOL`, 2: maximum error cycles per `clk_fb` period that still count as quiet.
- `LOCK_CNT`, 4: number of consecutive quiet periods required to assert `locked`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `en`  in  1  loop enable; 0 = holdover, error ignored.
- `up`  in  1  detector up pulse; reference leads.
- `down`  in  1  detector down pulse; feedback leads.
- `clk_out`  out  1  NCO output, equal to phase accumulator MSB.
- `clk_fb`  out  1  `clk_out` divided by `DIV_N`, 50% duty.
- `ftw`  out  ACC_W  current registered tuning word.
- `locked`  out  1  lock indicator.

## Operation
- Error decode each cycle: `err` = +1 if `en & up & ~down`; −1 if `en & down & ~up`; otherwise 0. Simultaneous `up` and `down`, or `en` = 0, gives 0.
- Integrator: `integ <= sat(integ + err*KI)`, saturating to ±(2^(CTRL_W−1)−1). Once saturated it holds; no wrap.
- Tuning word: `ftw <= clamp(FTW_NOM + sext(integ_next) + err*KP, 1, 2^(ACC_W−1))`. Computed at width ACC_W+2 before clamping. The proportional term lasts one cycle only.
- NCO: `phase <= phase + ftw` mod 2^ACC_W. `clk_out = phase[ACC_W−1]`, taken directly from the register so it is glitch-free.
- Divider: a rising edge of `clk_out` is detected as the registered MSB going 0→1. On each such edge, `cnt` wraps over 0..DIV_N−1. `clk_fb <= (cnt_next < DIV_N/2)`. Before the first `clk_out` edge after reset, `clk_fb` stays 0.
- Lock detector: `err_cnt` counts nonzero-`err` cycles and saturates at LOCK_TOL+1.
  - On each `clk_fb` rising edge: if `err_cnt ≤ LOCK_TOL`, increment `quiet` (saturating at LOCK_CNT); otherwise clear `quiet` and deassert `locked`. Then clear `err_cnt`.
  - `locked <= (quiet_next == LOCK_CNT)`.
- Holdover (`en` = 0): `integ` and `ftw` freeze at `FTW_NOM + integ`; the NCO and divider keep running.

## Timing
- Reset values when `rst_n` = 0 at an edge: `integ` = 0, `ftw` = FTW_NOM, `phase` = 0, `clk_out` = 0, `cnt` = 0, `clk_fb` = 0, `err_cnt` = 0, `quiet` = 0, `locked` = 0.
- Reset asserted mid-operation overrides every update in that same cycle.
- Latency:
  - `up` sampled at edge k → `ftw` updated after edge k.
  - The new `ftw` is first added to `phase` at edge k+1.
  - `clk_fb` changes one cycle after the `clk_out` rising edge that causes it.
- `locked` updates in the cycle after the `clk_fb` rising edge.

## Structure
- Package `dpll_pkg`:
  - `err_t` enum: `ERR_NONE`, `ERR_UP`, `ERR_DN`.
  - Saturating-add and clamp functions.
  - Default constants `FTW_NOM_DEF`, `KP_DEF`, `KI_DEF`.
- Sub-module `fb_divider`: `clk_out` edge detection, divide-by-N counter, `clk_fb` register. Instantiated once.
- The top level holds the filter, NCO and lock detector.

## Test plan
All scenarios use default parameters.
- Freerun: `en` = 0 after reset → `ftw` = 16'h1000; `clk_out` period 16 cycles; `clk_fb` period 64 cycles; `locked` = 0.
- Single `up` cycle with `en` = 1 → `ftw` = 16'h1110 for one cycle, then 16'h1010. A single `down` cycle instead → 16'h0EF0, then 16'h0FF0.
- `up` and `down` both high for 10 cycles → `ftw` stays 16'h1000 and `integ` stays 0.
- `up` held 200 cycles → `integ` saturates at 12'h7FF after cycle 128. After `up` is released, `ftw` = 16'h17FF and stays there.
- One `up` cycle per `clk_fb` period → `locked` = 1 after the 4th `clk_fb` rising edge. A 3-cycle `up` burst then clears `locked` at the next `clk_fb` rising edge.
- `rst_n` low for one edge while `ftw` = 16'h17FF and `locked` = 1 → the next cycle shows all reset values listed in Timing.
